// File: rtl/ser_pkg.sv
// Shared types and defaults for the bit serializer: FSM state type and default word width.
package ser_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

  localparam int SER_WIDTH_DEF = 8;

endpackage

// File: rtl/ser_bit_counter.sv
// Bit-index counter for the serializer: clears on clr, advances on inc, flags the last index.
module ser_bit_counter #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [CNT_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Parallel-in, serial-out stage feeding a sequence detector; MSB first by default.
// Define SER_LSB_FIRST_EN to emit LSB first instead.
module bit_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             x_out,
  output logic             bit_valid,
  output logic             frame_last,
  output logic             busy
);

  ser_state_t       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] shifted;
  logic             out_bit;
  logic             last;
  logic             wrap;
  logic             accept;

`ifdef SER_LSB_FIRST_EN
  assign out_bit = sreg[0];
  assign shifted = {1'b0, sreg[WIDTH-1:1]};
`else
  assign out_bit = sreg[WIDTH-1];
  assign shifted = {sreg[WIDTH-2:0], 1'b0};
`endif

  // Outputs are forced low while reset is asserted, even before state clears.
  assign busy       = ~reset & (state == SHIFT);
  assign bit_valid  = busy & shift_en;
  assign x_out      = bit_valid & out_bit;
  assign frame_last = busy & last;
  assign wrap       = bit_valid & frame_last;
  assign load_ready = ~reset & ((state == IDLE) | wrap);
  assign accept     = load_valid & load_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state <= SHIFT;
            sreg  <= data_in;
          end
        end
        SHIFT: begin
          // On the last bit a pending word reloads with no idle gap.
          if (wrap) begin
            if (accept) sreg <= data_in;
            else        state <= IDLE;
          end else if (bit_valid) begin
            sreg <= shifted;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  ser_bit_counter #(
    .WIDTH(WIDTH)
  ) u_cnt (
    .clk  (clk),
    .reset(reset),
    .clr  (accept | wrap),
    .inc  (bit_valid & ~frame_last),
    .last (last)
  );

endmodule

// File: tb/tb_bit_serializer.sv
// Directed, table-driven bench for bit_serializer, including a small 1101 detector model.
// Expected streams follow SER_LSB_FIRST_EN when it is defined.
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       load_valid;
  logic       load_ready;
  logic       shift_en;
  logic       x_out;
  logic       bit_valid;
  logic       frame_last;
  logic       busy;

  int n_vec  = 0;
  int n_fail = 0;
  logic [3:0] hist;
  logic       hit;

  typedef struct {
    logic [7:0] data;
    logic [7:0] stream;  // bits in emission order, first bit at [7]
    int         hit_at;  // bit index where 1101 completes, -1 if none
  } vec_t;

  vec_t vecs[7];

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .shift_en  (shift_en),
    .x_out     (x_out),
    .bit_valid (bit_valid),
    .frame_last(frame_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_bit(input string tag, input int i, input logic exp_x, input logic exp_last);
    check($sformatf("%s_busy%0d", tag, i), 32'(busy), 32'd1);
    check($sformatf("%s_valid%0d", tag, i), 32'(bit_valid), 32'd1);
    check($sformatf("%s_x%0d", tag, i), 32'(x_out), 32'(exp_x));
    check($sformatf("%s_last%0d", tag, i), 32'(frame_last), 32'(exp_last));
    hist = {hist[2:0], x_out};
    hit  = (hist == 4'b1101);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(bit_valid), 32'd0);
    check({tag, "_x"}, 32'(x_out), 32'd0);
    check({tag, "_ready"}, 32'(load_ready), 32'd1);
  endtask

  initial begin
`ifdef SER_LSB_FIRST_EN
    vecs[0] = '{8'h0B, 8'b1101_0000, 3};
    vecs[1] = '{8'hB0, 8'b0000_1101, 7};
    vecs[2] = '{8'h0D, 8'b1011_0000, -1};
    vecs[3] = '{8'h01, 8'b1000_0000, -1};
    vecs[4] = '{8'hFF, 8'b1111_1111, -1};
    vecs[5] = '{8'h55, 8'b1010_1010, -1};
    vecs[6] = '{8'h80, 8'b0000_0001, -1};
`else
    vecs[0] = '{8'hD0, 8'b1101_0000, 3};
    vecs[1] = '{8'h0D, 8'b0000_1101, 7};
    vecs[2] = '{8'hB0, 8'b1011_0000, -1};
    vecs[3] = '{8'h80, 8'b1000_0000, -1};
    vecs[4] = '{8'hFF, 8'b1111_1111, -1};
    vecs[5] = '{8'hAA, 8'b1010_1010, -1};
    vecs[6] = '{8'h01, 8'b0000_0001, -1};
`endif

    reset = 1'b1; data_in = '0; load_valid = 1'b1; shift_en = 1'b1; hist = '0; hit = 1'b0;
    @(negedge clk);
    #1;
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_valid", 32'(bit_valid), 32'd0);
    check("rst_x", 32'(x_out), 32'd0);
    check("rst_last", 32'(frame_last), 32'd0);
    step();
    reset = 1'b0; load_valid = 1'b0;
    #1;
    check_idle("post_rst");

    // Single words, shift_en held high.
    foreach (vecs[k]) begin
      step();
      hist = '0;
      data_in = vecs[k].data; load_valid = 1'b1; shift_en = 1'b1;
      #1;
      check($sformatf("w%0d_ready", k), 32'(load_ready), 32'd1);
      check($sformatf("w%0d_idle_x", k), 32'(x_out), 32'd0);
      step();
      load_valid = 1'b0; data_in = 8'h00;
      for (int i = 0; i < 8; i++) begin
        #1;
        check_bit($sformatf("w%0d", k), i, vecs[k].stream[7-i], i == 7);
        check($sformatf("w%0d_hit%0d", k, i), 32'(hit), 32'(i == vecs[k].hit_at));
        step();
      end
      #1;
      check_idle($sformatf("w%0d_end", k));
    end

    // Back-to-back words, load_valid always high: stream 0000_1101_1101_0000.
    step();
    hist = '0;
`ifdef SER_LSB_FIRST_EN
    data_in = 8'hB0;
`else
    data_in = 8'h0D;
`endif
    load_valid = 1'b1; shift_en = 1'b1;
    #1;
    check("b2b_ready0", 32'(load_ready), 32'd1);
    step();
    for (int i = 0; i < 16; i++) begin
      logic [15:0] s;
      s = 16'b0000_1101_1101_0000;
`ifdef SER_LSB_FIRST_EN
      data_in = (i < 8) ? 8'h0B : 8'h00;
`else
      data_in = (i < 8) ? 8'hD0 : 8'h00;
`endif
      load_valid = (i < 8);
      #1;
      check_bit("b2b", i, s[15-i], (i % 8) == 7);
      check($sformatf("b2b_ready%0d", i), 32'(load_ready), 32'((i % 8) == 7));
      check($sformatf("b2b_hit%0d", i), 32'(hit), 32'(i == 7 || i == 11));
      step();
    end
    #1;
    check_idle("b2b_end");

    // Stall after the 2nd bit, then stall again on the last bit with a word pending.
    step();
`ifdef SER_LSB_FIRST_EN
    data_in = 8'h0D;
`else
    data_in = 8'hB0;
`endif
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      logic [7:0] s;
      s = 8'b1011_0000;
      if (i >= 2 && i < 5) begin
        shift_en = 1'b0;
        #1;
        check($sformatf("stall_valid%0d", i), 32'(bit_valid), 32'd0);
        check($sformatf("stall_x%0d", i), 32'(x_out), 32'd0);
        check($sformatf("stall_busy%0d", i), 32'(busy), 32'd1);
        check($sformatf("stall_last%0d", i), 32'(frame_last), 32'd0);
      end else begin
        int b;
        b = (i < 2) ? i : i - 3;
        shift_en = 1'b1;
        if (b == 7) begin
          shift_en = 1'b0; load_valid = 1'b1; data_in = 8'hFF;
          #1;
          check("stall_lastbit_ready", 32'(load_ready), 32'd0);
          check("stall_lastbit_flag", 32'(frame_last), 32'd1);
          check("stall_lastbit_valid", 32'(bit_valid), 32'd0);
          step();
          shift_en = 1'b1; load_valid = 1'b0;
        end
        #1;
        check_bit("stall", b, s[7-b], b == 7);
      end
      step();
    end
    #1;
    check_idle("stall_end");

    // Reset at bit 4 of 8'hFF, then a fresh word.
    step();
    data_in = 8'hFF; load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_bit("mrst", i, 1'b1, 1'b0);
      step();
    end
    reset = 1'b1;
    #1;
    check("mrst_in_busy", 32'(busy), 32'd0);
    check("mrst_in_x", 32'(x_out), 32'd0);
    check("mrst_in_ready", 32'(load_ready), 32'd0);
    step();
    reset = 1'b0;
`ifdef SER_LSB_FIRST_EN
    data_in = 8'h01;
`else
    data_in = 8'h80;
`endif
    load_valid = 1'b1;
    #1;
    check_idle("mrst_after");
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_bit("mrst_new", i, i == 0, i == 7);
      step();
    end

    // load_valid held mid-word with changing data; only the accept-edge value is taken.
`ifdef SER_LSB_FIRST_EN
    data_in = 8'h55;
`else
    data_in = 8'hAA;
`endif
    load_valid = 1'b1;
    #1;
    check("hold_ready0", 32'(load_ready), 32'd1);
    step();
    for (int i = 0; i < 8; i++) begin
`ifdef SER_LSB_FIRST_EN
      data_in = (i < 3) ? 8'h33 : (i < 7) ? 8'hC3 : 8'h0F;
`else
      data_in = (i < 3) ? 8'h33 : (i < 7) ? 8'hC3 : 8'hF0;
`endif
      #1;
      check_bit("hold", i, ~i[0], i == 7);
      check($sformatf("hold_ready%0d", i), 32'(load_ready), 32'(i == 7));
      step();
    end
    load_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      check_bit("hold_next", i, i < 4, i == 7);
      step();
    end
    #1;
    check_idle("hold_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
